// File: rtl/wb_mem_responder.sv
// ---------------------------------------------------------------------------
// wb_mem_responder
//
// Wishbone classic responder that terminates the CPU's initiator cycles on
// the default leg of the read-data mux. Each accepted beat is decoded into
// DRAM, VRAM or BIOS ROM and becomes exactly one request/grant/read-valid
// transaction on the memory port. Good completions return a single-cycle
// ack; unmapped addresses, ROM writes and memory timeouts return a
// single-cycle err.
//
// Parameters
//   TIMEOUT  cycles allowed from mem_req to grant (or from grant to rvalid)
//            before the access is abandoned; 8-bit counter, must be >= 2
//   MEM_AW   width of the 32-bit word address presented on mem_addr
//
// Ports
//   sys_clk     sole clock
//   reset_n     synchronous active-low reset
//   i_wb_cyc    bus cycle
//   i_wb_stb    strobe
//   i_wb_we     1 = write
//   i_wb_adr    byte address, bits [1:0] ignored
//   i_wb_dat    write data
//   i_wb_sel    byte lanes
//   o_wb_dat    read data, meaningful only alongside o_wb_ack
//   o_wb_ack    one-cycle completion
//   o_wb_err    one-cycle error completion
//   mem_req     request, held until mem_gnt
//   mem_we      write request
//   mem_rgn     0 = DRAM, 1 = VRAM, 2 = ROM
//   mem_addr    word address within the region
//   mem_wdata   write data
//   mem_be      byte enables (copy of i_wb_sel)
//   mem_gnt     request accepted; writes complete here
//   mem_rvalid  read data valid, at least one cycle after mem_gnt
//   mem_rdata   read data
// ---------------------------------------------------------------------------
module wb_mem_responder #(
  parameter int TIMEOUT = 256,
  parameter int MEM_AW  = 22
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  output logic [31:0]       o_wb_dat,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_rgn,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RWAIT,
    S_DRAIN,
    S_ACK,
    S_ERR
  } state_t;

  localparam logic [1:0] RGN_DRAM = 2'd0;
  localparam logic [1:0] RGN_VRAM = 2'd1;
  localparam logic [1:0] RGN_ROM  = 2'd2;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_cnt;
  logic                r_err;
  logic [31:0]         r_dat;
  logic                r_mem_we;
  logic [1:0]          r_mem_rgn;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [3:0]          r_mem_be;

  logic                w_hit;
  logic [1:0]          w_rgn;
  logic [31:0]         w_base;
  logic [31:0]         w_offset;
  logic [MEM_AW-1:0]   w_word;
  logic                w_start;
  logic                w_reject;
  logic                w_timeout;
  logic                w_load;
  logic                w_capture;
  logic                w_err_set;

  // Address decode. The three windows are disjoint, so the first match wins
  // and everything outside them is reported as unmapped. The word address is
  // the offset from the window base with the byte-lane bits shifted away.
  always_comb begin
    w_hit  = 1'b0;
    w_rgn  = RGN_DRAM;
    w_base = 32'h0000_0000;
    if (i_wb_adr <= 32'h001F_FFFF) begin
      w_hit  = 1'b1;
      w_rgn  = RGN_DRAM;
      w_base = 32'h0000_0000;
    end else if (i_wb_adr <= 32'h002F_FFFF) begin
      w_hit  = 1'b1;
      w_rgn  = RGN_VRAM;
      w_base = 32'h0020_0000;
    end else if ((i_wb_adr >= 32'h0300_0000) && (i_wb_adr <= 32'h030F_FFFF)) begin
      w_hit  = 1'b1;
      w_rgn  = RGN_ROM;
      w_base = 32'h0300_0000;
    end
  end

  assign w_offset = i_wb_adr - w_base;
  assign w_word   = MEM_AW'(w_offset >> 2);

  // A new beat is only taken while no completion is on the bus, so the
  // master's still-asserted strobe during ack/err cannot start a second
  // access. Unmapped addresses and ROM writes never reach the memory port.
  assign w_start   = i_wb_cyc & i_wb_stb & ~o_wb_ack & ~o_wb_err;
  assign w_reject  = ~w_hit | ((w_rgn == RGN_ROM) & i_wb_we);
  assign w_timeout = (r_cnt == TO_LAST);

  // Next-state logic. A grant always wins over an abandoned cycle or a
  // timeout because the memory has already committed to the access. Once a
  // read is granted the memory owes us one rvalid, so any exit before it
  // arrives goes through DRAIN to keep a single request outstanding. A read
  // whose data lands after the master dropped cyc is consumed silently.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_reject) begin
            w_next    = S_ERR;
            w_err_set = 1'b1;
          end else begin
            w_next = S_REQ;
            w_load = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          w_next = r_mem_we ? S_ACK : S_RWAIT;
        end else if (!i_wb_cyc) begin
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_next    = S_ERR;
          w_err_set = 1'b1;
        end
      end
      S_RWAIT: begin
        if (mem_rvalid) begin
          if (i_wb_cyc) begin
            w_next    = S_ACK;
            w_capture = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end else if (!i_wb_cyc) begin
          w_next = S_DRAIN;
        end else if (w_timeout) begin
          w_next    = S_DRAIN;
          w_err_set = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) begin
          w_next = S_IDLE;
        end
      end
      S_ACK:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Timeout counter. It restarts whenever the state changes, so it measures
  // request-to-grant in REQ and grant-to-rvalid in RWAIT, and it sticks at
  // its maximum instead of wrapping.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Error pulse. Registered separately from the state so that a read
  // timeout can flag the error on the same edge it moves into DRAIN.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_set;
    end
  end

  // Request fields are captured once at acceptance and held stable for the
  // whole time mem_req is up.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_mem_we    <= 1'b0;
      r_mem_rgn   <= RGN_DRAM;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_load) begin
      r_mem_we    <= i_wb_we;
      r_mem_rgn   <= w_rgn;
      r_mem_addr  <= w_word;
      r_mem_wdata <= i_wb_dat;
      r_mem_be    <= i_wb_sel;
    end
  end

  // Read data register; it keeps the last returned word between acks.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_dat <= '0;
    end else if (w_capture) begin
      r_dat <= mem_rdata;
    end
  end

  assign o_wb_ack  = (r_state == S_ACK);
  assign o_wb_err  = r_err;
  assign o_wb_dat  = r_dat;
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_mem_we;
  assign mem_rgn   = r_mem_rgn;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule
